// File: rtl/sample_pacer_pkg.sv
// Shared types and helpers for the sample pacer slice.
package sample_pacer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } pacer_state_t;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered read data; occupancy tracked as a level
// count so full/empty never depend on pointer equality.
module sample_fifo
    import sample_pacer_pkg::*;
#(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk_i,
    input  logic                             srst_ni,
    input  logic                             push,
    input  logic                             pop,
    input  logic [DW-1:0]                    wr_data,
    output logic [DW-1:0]                    rd_data,
    output logic                             full,
    output logic                             empty,
    output logic [lvl_w(FIFO_DEPTH)-1:0]     level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = lvl_w(FIFO_DEPTH);

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage array; contents need no reset because reads only occur on valid entries.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, level and read-data register.
    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sample_pacer.sv
// Buffers a bursty valid/ready sample stream and re-issues samples as
// single-cycle strobes spaced at least CLK_PER_SAMPLE cycles apart.
// Optional feature macro: SAMPLE_PACER_STATS_EN (drop/underrun counters).
module sample_pacer
    import sample_pacer_pkg::*;
#(
    parameter int DW             = 16,
    parameter int CLK_PER_SAMPLE = 4,
    parameter int FIFO_DEPTH     = 8
`ifdef SAMPLE_PACER_STATS_EN
    ,
    parameter int CNT_W          = 16
`endif
) (
    input  logic                         clk_i,
    input  logic                         srst_ni,
    input  logic [DW-1:0]                data_i,
    input  logic                         data_valid_i,
    output logic                         ready_o,
    input  logic                         run_i,
    output logic [DW-1:0]                data_o,
    output logic                         sample_valid_o,
    output logic [lvl_w(FIFO_DEPTH)-1:0] level_o,
    output logic                         overflow_o
`ifdef SAMPLE_PACER_STATS_EN
    ,
    output logic [CNT_W-1:0]             ovf_cnt_o,
    output logic [CNT_W-1:0]             udr_cnt_o
`endif
);

    localparam int GW = $clog2(CLK_PER_SAMPLE) + 1;

    pacer_state_t  state;
    pacer_state_t  state_nxt;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_nxt;
    logic          pop;
    logic          full;
    logic          empty;

    assign ready_o = ~full;

    sample_fifo #(
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .srst_ni (srst_ni),
        .push    (data_valid_i),
        .pop     (pop),
        .wr_data (data_i),
        .rd_data (data_o),
        .full    (full),
        .empty   (empty),
        .level   (level_o)
    );

    // State register, gap counter, strobe register and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            state          <= IDLE;
            gap_cnt        <= '0;
            sample_valid_o <= 1'b0;
            overflow_o     <= 1'b0;
        end else begin
            state          <= state_nxt;
            gap_cnt        <= gap_nxt;
            sample_valid_o <= (state == EMIT);
            if (data_valid_i && full) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Next-state logic; EMIT pops so the strobe and data register update together.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (run_i && !empty) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                pop = 1'b1;
                if (CLK_PER_SAMPLE == 1) begin
                    // The entry being popped still counts in level, so require a second one.
                    state_nxt = (run_i && (level_o > 1)) ? EMIT : IDLE;
                end else begin
                    state_nxt = GAP;
                    gap_nxt   = GW'(CLK_PER_SAMPLE - 1);
                end
            end
            GAP: begin
                gap_nxt = gap_cnt - 1'b1;
                // Leave on the cycle the count reaches zero, keeping spacing exact.
                if (gap_cnt == GW'(1)) begin
                    state_nxt = (run_i && !empty) ? EMIT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SAMPLE_PACER_STATS_EN
    logic slot_q;

    // Saturating drop and underrun counters; an underrun is an idle slot right after a gap/emit.
    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            ovf_cnt_o <= '0;
            udr_cnt_o <= '0;
            slot_q    <= 1'b0;
        end else begin
            slot_q <= (state != IDLE) && (state_nxt == IDLE);
            if (data_valid_i && full && (ovf_cnt_o != '1)) begin
                ovf_cnt_o <= ovf_cnt_o + 1'b1;
            end
            if ((state == IDLE) && slot_q && run_i && empty && (udr_cnt_o != '1)) begin
                udr_cnt_o <= udr_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule
